// File: rtl/xor_inv_pkg.sv
// Shared types for the XOR/invert lane mapper: lane operation codes, the
// per-lane configuration record and the legacy power-up lane map.
package xor_inv_pkg;

  localparam int MAX_IN_W     = 64;
  localparam int MAX_SEL_W    = 6;
  localparam int LEGACY_LANES = 6;

  typedef enum logic [1:0] {
    OP_ZERO = 2'b00,
    OP_PASS = 2'b01,
    OP_INV  = 2'b10,
    OP_XOR  = 2'b11
  } op_e;

  // Selects are stored at the widest supported size so one record type
  // serves every parameterisation.
  typedef struct packed {
    op_e                  op;
    logic [MAX_SEL_W-1:0] sel_a;
    logic [MAX_SEL_W-1:0] sel_b;
  } lane_cfg_t;

  localparam lane_cfg_t CFG_ZERO = '{op: OP_ZERO, sel_a: 6'd0, sel_b: 6'd0};

  // Map inherited from the fixed 20-in/10-out mapper.
  localparam lane_cfg_t LEGACY_MAP [LEGACY_LANES] = '{
    '{OP_XOR, 6'd1, 6'd3},
    '{OP_XOR, 6'd2, 6'd4},
    '{OP_INV, 6'd5, 6'd0},
    '{OP_INV, 6'd6, 6'd0},
    '{OP_INV, 6'd7, 6'd0},
    '{OP_INV, 6'd8, 6'd0}
  };

  // Legacy entry for one lane; entries referring to bits the input vector
  // does not have collapse to ZERO.
  function automatic lane_cfg_t legacy_entry(input int lane, input int in_w);
    lane_cfg_t e;
    e = CFG_ZERO;
    if (lane >= 0 && lane < LEGACY_LANES) begin
      e = LEGACY_MAP[lane[2:0]];
      if (int'(e.sel_a) >= in_w || (e.op == OP_XOR && int'(e.sel_b) >= in_w)) begin
        e = CFG_ZERO;
      end else begin
        e = e;
      end
    end else begin
      e = CFG_ZERO;
    end
    return e;
  endfunction

endpackage

// File: rtl/xor_inv_stage.sv
// One valid/ready pipeline register. It loads whenever it is empty or its
// downstream neighbour takes the current contents this cycle.
module xor_inv_stage #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         up_ready,
  output logic         dn_valid,
  output logic [W-1:0] dn_data,
  input  logic         dn_ready
);

  logic         valid_r;
  logic [W-1:0] data_r;

  assign up_ready = !valid_r || dn_ready;
  assign dn_valid = valid_r;
  assign dn_data  = data_r;

  // Stage register: take upstream contents when allowed, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (up_ready) begin
      valid_r <= up_valid;
      if (up_valid) begin
        data_r <= up_data;
      end
    end
  end

endmodule

// File: rtl/xor_inv_pipe.sv
// Runtime-configurable XOR/invert lane mapper feeding a PIPE-deep
// valid/ready pipeline, with a 16-bit completed-transfer counter.
module xor_inv_pipe
  import xor_inv_pkg::*;
#(
  parameter int IN_W   = 20,
  parameter int OUT_W  = 10,
  parameter int PIPE   = 2,
  parameter int SEL_W  = (IN_W > 1) ? $clog2(IN_W) : 1,
  parameter int LANE_W = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cfg_we,
  input  logic [LANE_W-1:0] cfg_lane,
  input  logic [1:0]        cfg_op,
  input  logic [SEL_W-1:0]  cfg_sel_a,
  input  logic [SEL_W-1:0]  cfg_sel_b,
  output logic              cfg_err,
  output logic [15:0]       xfer_cnt,
  output logic              busy
);

  lane_cfg_t        cfg_table_r [OUT_W];
  logic             cfg_ok_s;
  logic [OUT_W-1:0] lane_res_s;
  logic             cfg_err_r;
  logic [15:0]      xfer_cnt_r;
  logic             busy_s;

  logic             stg_valid_s [0:PIPE];
  logic [OUT_W-1:0] stg_data_s  [0:PIPE];
  logic             stg_ready_s [1:PIPE+1];

  // Evaluate one lane; the input is widened so any stored select indexes it.
  function automatic logic lane_eval(input lane_cfg_t c, input logic [IN_W-1:0] v);
    logic [MAX_IN_W-1:0] vx;
    logic                a;
    logic                b;
    logic                r;
    vx = MAX_IN_W'(v);
    a  = vx[c.sel_a];
    b  = vx[c.sel_b];
    case (c.op)
      OP_ZERO: r = 1'b0;
      OP_PASS: r = a;
      OP_INV:  r = ~a;
      OP_XOR:  r = a ^ b;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Range check of a configuration write; sel_b only matters for XOR.
  always_comb begin
    cfg_ok_s = 1'b1;
    if (32'(cfg_lane) >= 32'(OUT_W)) begin
      cfg_ok_s = 1'b0;
    end else if (32'(cfg_sel_a) >= 32'(IN_W)) begin
      cfg_ok_s = 1'b0;
    end else if (cfg_op == 2'b11 && 32'(cfg_sel_b) >= 32'(IN_W)) begin
      cfg_ok_s = 1'b0;
    end else begin
      cfg_ok_s = 1'b1;
    end
  end

  // Lane table: legacy map out of reset, updated by accepted writes. The
  // accepted vector on a write edge still sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_W; i++) begin
        cfg_table_r[i] <= legacy_entry(i, IN_W);
      end
    end else if (cfg_we && cfg_ok_s) begin
      cfg_table_r[cfg_lane] <= '{op:    op_e'(cfg_op),
                                 sel_a: MAX_SEL_W'(cfg_sel_a),
                                 sel_b: MAX_SEL_W'(cfg_sel_b)};
    end
  end

  // Rejected-write flag, one cycle after the offending strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_we && !cfg_ok_s;
    end
  end

  // Per-lane results for the vector currently presented at the input.
  always_comb begin
    lane_res_s = '0;
    for (int i = 0; i < OUT_W; i++) begin
      lane_res_s[i] = lane_eval(cfg_table_r[i], in);
    end
  end

  assign stg_valid_s[0]      = in_valid;
  assign stg_data_s[0]       = lane_res_s;
  assign stg_ready_s[PIPE+1] = out_ready;

  for (genvar k = 1; k <= PIPE; k++) begin : g_stage
    xor_inv_stage #(.W(OUT_W)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (stg_valid_s[k-1]),
      .up_data  (stg_data_s[k-1]),
      .up_ready (stg_ready_s[k]),
      .dn_valid (stg_valid_s[k]),
      .dn_data  (stg_data_s[k]),
      .dn_ready (stg_ready_s[k+1])
    );
  end

  // Any stage holding a vector keeps the block busy.
  always_comb begin
    busy_s = 1'b0;
    for (int k = 1; k <= PIPE; k++) begin
      busy_s = busy_s | stg_valid_s[k];
    end
  end

  // Completed output transfers, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_r <= 16'd0;
    end else if (stg_valid_s[PIPE] && out_ready) begin
      xfer_cnt_r <= xfer_cnt_r + 16'd1;
    end
  end

  assign in_ready  = stg_ready_s[1];
  assign out       = stg_data_s[PIPE];
  assign out_valid = stg_valid_s[PIPE];
  assign cfg_err   = cfg_err_r;
  assign xfer_cnt  = xfer_cnt_r;
  assign busy      = busy_s;

endmodule

// File: tb/tb_xor_inv_pipe.sv
// Randomised and directed bench for xor_inv_pipe against a queue-based model.
module tb_xor_inv_pipe;

  localparam int IN_W   = 20;
  localparam int OUT_W  = 10;
  localparam int PIPE   = 2;
  localparam int SEL_W  = 5;
  localparam int LANE_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [IN_W-1:0]   din = '0;
  logic              din_valid = 1'b0;
  logic              in_ready;
  logic [OUT_W-1:0]  dout;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              cfg_we = 1'b0;
  logic [LANE_W-1:0] cfg_lane = '0;
  logic [1:0]        cfg_op = '0;
  logic [SEL_W-1:0]  cfg_sel_a = '0;
  logic [SEL_W-1:0]  cfg_sel_b = '0;
  logic              cfg_err;
  logic [15:0]       xfer_cnt;
  logic              busy;

  xor_inv_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .PIPE(PIPE)) dut (
    .clk(clk), .rst_n(rst_n), .in(din), .in_valid(din_valid), .in_ready(in_ready),
    .out(dout), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_op(cfg_op),
    .cfg_sel_a(cfg_sel_a), .cfg_sel_b(cfg_sel_b), .cfg_err(cfg_err),
    .xfer_cnt(xfer_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: lane table as plain integers, in-flight results as a queue.
  int               m_op [OUT_W];
  int               m_a  [OUT_W];
  int               m_b  [OUT_W];
  logic [OUT_W-1:0] exp_q [$];
  logic [OUT_W-1:0] got_q [$];
  int               exp_cnt = 0;
  bit               exp_err = 1'b0;
  bit               last_acc;
  bit               last_cmp;
  logic [OUT_W-1:0] last_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < OUT_W; i++) begin
      m_op[i] = 0; m_a[i] = 0; m_b[i] = 0;
    end
    m_op[0] = 3; m_a[0] = 1; m_b[0] = 3;
    m_op[1] = 3; m_a[1] = 2; m_b[1] = 4;
    for (int i = 2; i <= 5; i++) begin
      m_op[i] = 2; m_a[i] = i + 3;
    end
  endfunction

  function automatic logic [OUT_W-1:0] model_out(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < OUT_W; i++) begin
      case (m_op[i])
        1:       r[i] = v[m_a[i]];
        2:       r[i] = ~v[m_a[i]];
        3:       r[i] = v[m_a[i]] ^ v[m_b[i]];
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // One clock: check before the edge, update the model at the edge, check after.
  task automatic tick();
    bit ok;
    #1;
    chk("in_ready", in_ready, (exp_q.size() < PIPE) || out_ready);
    if (out_valid) begin
      chk("out_valid_backed", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("out_data", dout, exp_q[0]);
    end
    last_acc = din_valid && in_ready;
    last_cmp = out_valid && out_ready;
    last_out = dout;
    @(posedge clk);
    if (last_cmp) begin
      got_q.push_back(last_out);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      exp_cnt = (exp_cnt + 1) % 65536;
    end
    if (last_acc) exp_q.push_back(model_out(din));
    exp_err = 1'b0;
    if (cfg_we) begin
      ok = (int'(cfg_lane) < OUT_W) && (int'(cfg_sel_a) < IN_W) &&
           (cfg_op != 2'b11 || int'(cfg_sel_b) < IN_W);
      if (ok) begin
        m_op[cfg_lane] = int'(cfg_op);
        m_a[cfg_lane]  = int'(cfg_sel_a);
        m_b[cfg_lane]  = int'(cfg_sel_b);
      end else begin
        exp_err = 1'b1;
      end
    end
    @(negedge clk);
    chk("cfg_err", cfg_err, exp_err);
    chk("xfer_cnt", xfer_cnt, exp_cnt);
    chk("busy", busy, exp_q.size() != 0);
  endtask

  task automatic drain();
    din_valid = 1'b0;
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic cfg_write(input int lane, input int op, input int a, input int b);
    cfg_we = 1'b1; cfg_lane = LANE_W'(lane); cfg_op = 2'(op);
    cfg_sel_a = SEL_W'(a); cfg_sel_b = SEL_W'(b);
  endtask

  initial begin
    int acc_n;
    model_reset();
    chk("pin_model_3d", model_out(20'h00002), 10'h03D);
    chk("pin_model_000", model_out(20'h001E0), 10'h000);
    chk("pin_model_03c", model_out(20'h0001E), 10'h03C);

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", dout, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency and back-to-back streaming.
    out_ready = 1'b1;
    din = 20'h00002; din_valid = 1'b1; tick();
    chk("lat_not_yet", out_valid, 0);
    din = 20'h001E0; tick();
    chk("lat_valid", out_valid, 1);
    chk("first_out", dout, 10'h03D);
    din = 20'h0001E; tick();
    chk("second_out", dout, 10'h000);
    chk("cnt_one", xfer_cnt, 1);
    din_valid = 1'b0; tick();
    chk("third_out", dout, 10'h03C);
    drain();

    // Backpressure: two accepts fill the pipe, then release.
    out_ready = 1'b0; acc_n = 0; din = 20'($urandom);
    for (int i = 0; i < 5; i++) begin
      din_valid = (acc_n < 3);
      tick();
      if (last_acc) begin acc_n++; din = 20'($urandom); end
    end
    chk("stall_accepts", acc_n, 2);
    chk("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && acc_n < 3; i++) begin
      din_valid = 1'b1; tick();
      if (last_acc) acc_n++;
    end
    drain();

    // Lane 6 reconfigured as XOR(0,19); out-of-range lane is rejected.
    cfg_write(6, 3, 0, 19); tick(); cfg_we = 1'b0;
    got_q.delete();
    din = 20'h80000; din_valid = 1'b1; tick();
    drain();
    cfg_write(12, 1, 0, 0); tick();
    chk("cfg_err_pulse", cfg_err, 1);
    cfg_we = 1'b0; tick();
    chk("cfg_err_clear", cfg_err, 0);
    din = 20'h80000; din_valid = 1'b1; tick();
    drain();
    chk("lane6_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("lane6_xor", got_q[0], 10'h07C);
      chk("table_unchanged", got_q[1], 10'h07C);
    end

    // Write on the same edge as an accept: old map for that vector.
    got_q.delete();
    cfg_write(0, 0, 0, 0); din = 20'h00002; din_valid = 1'b1; tick();
    cfg_we = 1'b0; tick();
    drain();
    chk("same_edge_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("same_edge_old", got_q[0], 10'h03D);
      chk("same_edge_new", got_q[1], 10'h03C);
    end

    // Random traffic with random config writes (some rejected).
    for (int i = 0; i < 400; i++) begin
      din       = 20'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0)
        cfg_write($urandom_range(0, 15), $urandom_range(0, 3),
                  $urandom_range(0, 31), $urandom_range(0, 31));
      else
        cfg_we = 1'b0;
      tick();
    end
    drain();

    // Counter wrap via continuous streaming.
    din_valid = 1'b1; out_ready = 1'b1; cfg_we = 1'b0;
    for (int i = 0; i < 70000 && exp_cnt != 65535; i++) begin
      din = 20'($urandom); tick();
    end
    chk("cnt_ffff", xfer_cnt, 16'hFFFF);
    tick();
    chk("cnt_wrap", xfer_cnt, 16'h0000);

    // Reset mid-stream.
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt", xfer_cnt, 0);
    din_valid = 1'b0;
    exp_q.delete(); model_reset(); exp_cnt = 0;
    @(posedge clk); @(negedge clk);
    chk("midrst_cnt_edge", xfer_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    got_q.delete();
    din = 20'h80000; din_valid = 1'b1; tick();
    drain();
    chk("legacy_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("legacy_restored", got_q[0], 10'h03C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
